vram_dma: RTL and testbench
===========================

VRAM_DMA -- requirements
Module: vram_dma

Interface
REQ-001 clk  input  1  system clock, 4.19 MHz.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 ct  input  2  T-cycle index within the current M-cycle.
REQ-004 mmio_a  input  16  CPU address.
REQ-005 mmio_din  input  8  CPU write data.
REQ-006 mmio_dout  output  8  register read data.
REQ-007 mmio_rd  input  1  CPU read strobe.
REQ-008 mmio_wr  input  1  CPU write strobe, pre-decoded for 0xFF51-0xFF55.
REQ-009 hblank  input  1  high while the PPU is in mode 0.
REQ-010 src_a  output  16  source address, to the external/WRAM bus.
REQ-011 src_rd  output  1  source read enable.
REQ-012 src_din  input  8  source read data.
REQ-013 vram_a  output  13  VRAM byte offset.
REQ-014 vram_dout  output  8  VRAM write data.
REQ-015 vram_wr  output  1  VRAM write enable.
REQ-016 occupy  output  1  the block owns the source bus and VRAM bus; the CPU is stalled.

Function
REQ-017 Registers: 0xFF51 holds source[15:8]; 0xFF52 holds source[7:4], with bits 3:0 ignored; 0xFF53 holds dest[12:8] from bits 4:0; 0xFF54 holds dest[7:4].
REQ-018 Writes to 0xFF51-0xFF54 update only the shadow registers; working counters load from the shadows only at start.
REQ-019 Reads of 0xFF51-0xFF54 return 0xFF.
REQ-020 0xFF55 read returns:
  - {0, blocks_left-1} while active;
  - 0xFF after normal completion;
  - {1, blocks_left-1} after a cancel.
REQ-021 0xFF55 write in IDLE: blocks = data[6:0]+1, each block 16 bytes.
  - data[7]=0 starts GDMA.
  - data[7]=1 starts HDMA.
REQ-022 0xFF55 write with data[7]=0 while HDMA is in HWAIT or HDONE cancels the transfer: go to IDLE, keep blocks_left.
REQ-023 A cancel write arriving during HBLOCK takes effect when the current block completes.
REQ-024 0xFF55 writes with data[7]=1 while active are ignored.
REQ-025 States are IDLE, GDMA, HWAIT, HBLOCK and HDONE.
REQ-026 GDMA copies all blocks back-to-back, then goes to IDLE.
REQ-027 HWAIT goes to HBLOCK on the first cycle hblank=1, including immediately if hblank is already high at start.
REQ-028 HBLOCK copies exactly 16 bytes, then:
  - goes to IDLE if blocks_left reaches 0;
  - otherwise goes to HDONE.
REQ-029 HDONE goes to HWAIT when hblank=0, so there is one block per HBlank.
REQ-030 Byte transfer occupies one M-cycle, starting on ct=0 after entry to GDMA or HBLOCK:
  - ct=0,1: src_a = source counter, src_rd=1;
  - src_din is latched at the end of ct=1;
  - ct=2: vram_a = dest counter, vram_dout = latched byte, vram_wr=1 for exactly one clk;
  - both counters increment after ct=3.
REQ-031 A 16-byte block therefore takes 64 clk.
REQ-032 The dest counter is 13 bits.
REQ-033 If the dest counter wraps from 0x1FFF to 0x0000, the transfer terminates as normal completion (state IDLE, read 0xFF).
REQ-034 The source counter is 16 bits and wraps modulo 2^16.
REQ-035 occupy=1 exactly in GDMA and HBLOCK, including any wait for ct=0.
REQ-036 src_rd=0 and vram_wr=0 in all other states.
REQ-037 Simultaneous events: an MMIO write and counter increment in the same clk are independent, because the shadow and working registers are separate.
REQ-038 The hblank rising edge in the same clk as an HDMA start is honoured per REQ-027.

Reset
REQ-039 On rst=1 at a clk edge, the block goes to IDLE and all shadow registers and counters clear to 0.
REQ-040 After reset, occupy=0, src_rd=0, vram_wr=0, and 0xFF55 reads 0xFF.
REQ-041 Reset mid-transfer aborts immediately; no further VRAM write occurs.

Verification
REQ-042 GDMA: write FF51=0xC1, FF52=0x2F, FF53=0x80, FF54=0x40, FF55=0x01 -> 32 bytes copied from 0xC120 to VRAM 0x0040-0x005F; occupy high for 128 clk ±3 alignment; FF55 then reads 0xFF.
REQ-043 HDMA: FF55=0x82 with hblank toggling -> exactly 16 writes per hblank pulse, 3 pulses total; FF55 reads 0x01, then 0x00, then 0xFF.
REQ-044 Cancel: HDMA with 4 blocks; write FF55=0x00 in HDONE after block 1 -> IDLE, no writes on later hblank, FF55 reads 0x82.
REQ-045 Wrap: dest 0x1FF0, FF55=0x01 -> 16 bytes written to 0x1FF0-0x1FFF, then IDLE and FF55 reads 0xFF.
REQ-046 Reset: assert rst during byte 5 of a GDMA -> occupy=0 and vram_wr=0 on the next clk, FF55 reads 0xFF.

Source files
------------

// File: rtl/vram_dma_if.sv
// ============================================================================
// Module   : vram_dma_if
// Purpose  : CPU register port, source-bus and VRAM-bus signals of vram_dma.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface vram_dma_if;
  logic [15:0] mmio_a;
  logic [7:0]  mmio_din;
  logic [7:0]  mmio_dout;
  logic        mmio_rd;
  logic        mmio_wr;
  logic [15:0] src_a;
  logic        src_rd;
  logic [7:0]  src_din;
  logic [12:0] vram_a;
  logic [7:0]  vram_dout;
  logic        vram_wr;

  modport master (
    output mmio_a, mmio_din, mmio_rd, mmio_wr, src_din,
    input  mmio_dout, src_a, src_rd, vram_a, vram_dout, vram_wr
  );

  modport slave (
    input  mmio_a, mmio_din, mmio_rd, mmio_wr, src_din,
    output mmio_dout, src_a, src_rd, vram_a, vram_dout, vram_wr
  );
endinterface

`default_nettype wire

// File: rtl/vram_dma.sv
// ============================================================================
// Module   : vram_dma
// Purpose  : General-purpose and HBlank-paced block copy into VRAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vram_dma (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [1:0] ct,
  input  wire logic       hblank,
  output logic            occupy,
  vram_dma_if.slave       bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GDMA   = 3'd1,
    S_HWAIT  = 3'd2,
    S_HBLOCK = 3'd3,
    S_HDONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [7:0]  r_src_hi;
  logic [3:0]  r_src_lo;
  logic [4:0]  r_dst_hi;
  logic [3:0]  r_dst_lo;

  logic [15:0] r_src_cnt;
  logic [12:0] r_dst_cnt;
  logic [7:0]  r_blocks_left;
  logic [3:0]  r_byte_cnt;
  logic        r_busy;
  logic [7:0]  r_data;
  logic        r_cancel_pend;
  logic        r_cancelled;

  logic        w_xfer_st;
  logic        w_wr55;
  logic        w_cancel_req;
  logic        w_start;
  logic        w_byte_end;
  logic        w_blk_end;
  logic        w_done;
  logic        w_cancel_now;
  logic        w_blk_cancel;
  logic [6:0]  w_bl_m1;

  assign w_xfer_st    = (r_state == S_GDMA) || (r_state == S_HBLOCK);
  assign w_wr55       = bus.mmio_wr && (bus.mmio_a == 16'hFF55);
  assign w_cancel_req = w_wr55 && !bus.mmio_din[7];
  assign w_start      = w_wr55 && (r_state == S_IDLE);
  // A byte ends on ct=3 only if its ct=0 was seen inside the copy state.
  assign w_byte_end   = w_xfer_st && r_busy && (ct == 2'd3);
  assign w_blk_end    = w_byte_end && (r_byte_cnt == 4'hF);
  assign w_done       = (w_blk_end && (r_blocks_left == 8'd1)) ||
                        (w_byte_end && (r_dst_cnt == 13'h1FFF));
  assign w_cancel_now = w_cancel_req && ((r_state == S_HWAIT) || (r_state == S_HDONE));
  assign w_blk_cancel = (r_state == S_HBLOCK) && w_blk_end && !w_done &&
                        (r_cancel_pend || w_cancel_req);
  assign w_bl_m1      = r_blocks_left[6:0] - 7'd1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_wr55) w_next = bus.mmio_din[7] ? S_HWAIT : S_GDMA;
      S_GDMA:   if (w_done) w_next = S_IDLE;
      S_HWAIT: begin
        if (w_cancel_now) w_next = S_IDLE;
        else if (hblank)  w_next = S_HBLOCK;
      end
      S_HBLOCK: begin
        if (w_done || w_blk_cancel) w_next = S_IDLE;
        else if (w_blk_end)         w_next = S_HDONE;
      end
      S_HDONE: begin
        if (w_cancel_now) w_next = S_IDLE;
        else if (!hblank) w_next = S_HWAIT;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_hi      <= 8'h00;
      r_src_lo      <= 4'h0;
      r_dst_hi      <= 5'h00;
      r_dst_lo      <= 4'h0;
      r_src_cnt     <= 16'h0000;
      r_dst_cnt     <= 13'h0000;
      r_blocks_left <= 8'h00;
      r_byte_cnt    <= 4'h0;
      r_busy        <= 1'b0;
      r_data        <= 8'h00;
      r_cancel_pend <= 1'b0;
      r_cancelled   <= 1'b0;
    end else begin
      // Shadow registers are written independently of the working counters.
      if (bus.mmio_wr) begin
        case (bus.mmio_a)
          16'hFF51: r_src_hi <= bus.mmio_din;
          16'hFF52: r_src_lo <= bus.mmio_din[7:4];
          16'hFF53: r_dst_hi <= bus.mmio_din[4:0];
          16'hFF54: r_dst_lo <= bus.mmio_din[7:4];
          default: ;
        endcase
      end

      if (w_start) begin
        r_src_cnt     <= {r_src_hi, r_src_lo, 4'h0};
        r_dst_cnt     <= {r_dst_hi, r_dst_lo, 4'h0};
        r_blocks_left <= {1'b0, bus.mmio_din[6:0]} + 8'd1;
        r_byte_cnt    <= 4'h0;
        r_cancel_pend <= 1'b0;
        r_cancelled   <= 1'b0;
      end

      if (w_xfer_st && (ct == 2'd0))       r_busy <= 1'b1;
      else if (!w_xfer_st || (ct == 2'd3)) r_busy <= 1'b0;

      if (w_xfer_st && r_busy && (ct == 2'd1)) r_data <= bus.src_din;

      if (w_byte_end) begin
        r_src_cnt  <= r_src_cnt + 16'd1;
        r_dst_cnt  <= r_dst_cnt + 13'd1;
        r_byte_cnt <= r_byte_cnt + 4'd1;
        if (w_blk_end) r_blocks_left <= r_blocks_left - 8'd1;
      end

      // A cancel seen mid-block is held until the block boundary.
      if ((r_state == S_HBLOCK) && w_cancel_req) r_cancel_pend <= 1'b1;
      if (w_cancel_now || w_blk_cancel)          r_cancelled   <= 1'b1;
    end
  end

  always_comb begin
    bus.mmio_dout = 8'hFF;
    if (bus.mmio_rd && (bus.mmio_a == 16'hFF55)) begin
      if (r_state != S_IDLE) bus.mmio_dout = {1'b0, w_bl_m1};
      else if (r_cancelled)  bus.mmio_dout = {1'b1, w_bl_m1};
    end
  end

  assign occupy        = w_xfer_st;
  assign bus.src_a     = r_src_cnt;
  assign bus.src_rd    = w_xfer_st && ((ct == 2'd0) || (r_busy && (ct == 2'd1)));
  assign bus.vram_a    = r_dst_cnt;
  assign bus.vram_dout = r_data;
  assign bus.vram_wr   = w_xfer_st && r_busy && (ct == 2'd2);

endmodule

`default_nettype wire

// File: tb/tb_vram_dma.sv
// ============================================================================
// Module   : tb_vram_dma
// Purpose  : Directed scoreboard bench for vram_dma.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vram_dma;
  logic       clk;
  logic       rst;
  logic [1:0] ct;
  logic       hblank;
  logic       occupy;

  vram_dma_if bus ();

  vram_dma dut (
    .clk    (clk),
    .rst    (rst),
    .ct     (ct),
    .hblank (hblank),
    .occupy (occupy),
    .bus    (bus.slave)
  );

  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  assign bus.src_din = mem(bus.src_a);

  int passed = 0;
  int total  = 0;
  int failed = 0;
  int wr_cnt = 0;
  bit sb_en  = 1'b1;
  logic [20:0] sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) ct = ct + 2'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every VRAM write pops one expected {addr, data}.
  always @(negedge clk) begin
    logic [20:0] e;
    #1;
    if (bus.vram_wr === 1'b1) begin
      wr_cnt++;
      if (sb_en) begin
        if (sb.size() == 0) check("sb_unexpected_write", {19'd0, bus.vram_a}, 32'hFFFF);
        else begin
          e = sb.pop_front();
          check("vram_addr", {19'd0, bus.vram_a}, {19'd0, e[20:8]});
          check("vram_data", {24'd0, bus.vram_dout}, {24'd0, e[7:0]});
        end
      end
    end
  end

  task automatic push_exp(input logic [15:0] s, input logic [12:0] d, input int n);
    for (int i = 0; i < n; i++) sb.push_back({d + 13'(i), mem(s + 16'(i))});
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.mmio_a = a; bus.mmio_din = d; bus.mmio_wr = 1'b1;
    @(negedge clk);
    bus.mmio_wr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.mmio_a = a; bus.mmio_rd = 1'b1;
    #2;
    d = bus.mmio_dout;
    bus.mmio_rd = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int lim);
    bit ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk); #2;
      if (!occupy) begin ok = 1'b1; break; end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] exp_h[3];
    int base;
    int occ;
    bit ok;
    exp_h[0] = 8'h01; exp_h[1] = 8'h00; exp_h[2] = 8'hFF;
    ct = 2'd0; rst = 1'b1; hblank = 1'b0;
    bus.mmio_a = 16'h0000; bus.mmio_din = 8'h00; bus.mmio_rd = 1'b0; bus.mmio_wr = 1'b0;
    cycles(4);
    rst = 1'b0;
    @(negedge clk); #2;
    check("rst_occupy", {31'd0, occupy}, 32'd0);
    check("rst_src_rd", {31'd0, bus.src_rd}, 32'd0);
    check("rst_vram_wr", {31'd0, bus.vram_wr}, 32'd0);
    rd(16'hFF55, d); check("rst_ff55", {24'd0, d}, 32'hFF);
    rd(16'hFF51, d); check("rd_ff51", {24'd0, d}, 32'hFF);

    // GDMA, 2 blocks from 0xC120 to 0x0040.
    wr(16'hFF51, 8'hC1); wr(16'hFF52, 8'h2F); wr(16'hFF53, 8'h80); wr(16'hFF54, 8'h40);
    push_exp(16'hC120, 13'h0040, 32);
    base = wr_cnt; occ = 0; ok = 1'b0;
    wr(16'hFF55, 8'h01);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #2;
      if (occupy) occ++;
      else if (occ > 0) begin ok = 1'b1; break; end
    end
    check("gdma_finished", {31'd0, ok}, 32'd1);
    check("gdma_occupy_len", {31'd0, (occ >= 125 && occ <= 131)}, 32'd1);
    check("gdma_writes", wr_cnt - base, 32'd32);
    check("gdma_sb_empty", sb.size(), 32'd0);
    rd(16'hFF55, d); check("gdma_ff55", {24'd0, d}, 32'hFF);

    // HDMA, 3 blocks, one per HBlank.
    wr(16'hFF51, 8'h12); wr(16'hFF52, 8'h34); wr(16'hFF53, 8'h05); wr(16'hFF54, 8'h60);
    push_exp(16'h1230, 13'h0560, 48);
    wr(16'hFF55, 8'h82);
    rd(16'hFF55, d); check("hdma_ff55_wait", {24'd0, d}, 32'h02);
    for (int p = 0; p < 3; p++) begin
      base = wr_cnt;
      @(negedge clk); hblank = 1'b1;
      cycles(76);
      hblank = 1'b0;
      cycles(6);
      check("hdma_pulse_writes", wr_cnt - base, 32'd16);
      rd(16'hFF55, d); check("hdma_ff55", {24'd0, d}, {24'd0, exp_h[p]});
    end
    check("hdma_sb_empty", sb.size(), 32'd0);

    // Cancel in HDONE after the first of 4 blocks.
    push_exp(16'h1230, 13'h0560, 16);
    wr(16'hFF55, 8'h83);
    base = wr_cnt;
    @(negedge clk); hblank = 1'b1;
    cycles(75);
    wr(16'hFF55, 8'h00);
    hblank = 1'b0;
    cycles(4);
    check("cancel_first_block", wr_cnt - base, 32'd16);
    rd(16'hFF55, d); check("cancel_ff55", {24'd0, d}, 32'h82);
    base = wr_cnt;
    @(negedge clk); hblank = 1'b1;
    cycles(76);
    hblank = 1'b0;
    #2;
    check("cancel_no_writes", wr_cnt - base, 32'd0);
    check("cancel_occupy", {31'd0, occupy}, 32'd0);
    rd(16'hFF55, d); check("cancel_ff55_again", {24'd0, d}, 32'h82);

    // HDMA started with hblank already high.
    wr(16'hFF53, 8'h02); wr(16'hFF54, 8'h00);
    push_exp(16'h1230, 13'h0200, 16);
    base = wr_cnt;
    @(negedge clk); hblank = 1'b1;
    wr(16'hFF55, 8'h80);
    cycles(80);
    hblank = 1'b0;
    cycles(4);
    check("hdma_hi_writes", wr_cnt - base, 32'd16);
    rd(16'hFF55, d); check("hdma_hi_ff55", {24'd0, d}, 32'hFF);

    // Dest wrap ends the transfer after 16 bytes.
    wr(16'hFF51, 8'hAB); wr(16'hFF52, 8'hC0); wr(16'hFF53, 8'h1F); wr(16'hFF54, 8'hF0);
    push_exp(16'hABC0, 13'h1FF0, 16);
    base = wr_cnt;
    wr(16'hFF55, 8'h01);
    wait_idle("wrap_idle", 300);
    cycles(4);
    check("wrap_writes", wr_cnt - base, 32'd16);
    check("wrap_sb_empty", sb.size(), 32'd0);
    rd(16'hFF55, d); check("wrap_ff55", {24'd0, d}, 32'hFF);

    // Reset during byte 5 of a GDMA.
    sb_en = 1'b0;
    base = wr_cnt;
    wr(16'hFF55, 8'h00);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if ((wr_cnt - base) == 4 && bus.src_rd) begin ok = 1'b1; break; end
    end
    check("rst_mid_reach_byte5", {31'd0, ok}, 32'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #2;
    check("rst_mid_occupy", {31'd0, occupy}, 32'd0);
    check("rst_mid_vram_wr", {31'd0, bus.vram_wr}, 32'd0);
    rst = 1'b0;
    cycles(20);
    check("rst_mid_writes", wr_cnt - base, 32'd4);
    rd(16'hFF55, d); check("rst_mid_ff55", {24'd0, d}, 32'hFF);

    // Shadows cleared by reset: copy from 0x0000 to 0x0000.
    sb_en = 1'b1;
    push_exp(16'h0000, 13'h0000, 16);
    base = wr_cnt;
    wr(16'hFF55, 8'h00);
    wait_idle("post_rst_idle", 200);
    cycles(4);
    check("post_rst_writes", wr_cnt - base, 32'd16);
    check("post_rst_sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

`default_nettype wire
